// File: rtl/comparator_nb_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator that scans DIGIT-bit slices MSB-first behind a start/done handshake.
// Signed mode flips the sign bit of both operands when they are latched, so one unsigned scan handles both modes.
module comparator_nb_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_great_B,
    output logic             A_equal_B,
    output logic             A_less_B
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST     = CW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("comparator_nb_seq: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    idx;
    logic [DIGIT-1:0] a_slice;
    logic [DIGIT-1:0] b_slice;
    logic             slice_differs;
    logic             last_slice;

    // The operand registers shift left each step, so the slice under test is always the top DIGIT bits.
    assign a_slice       = a_q[WIDTH-1 -: DIGIT];
    assign b_slice       = b_q[WIDTH-1 -: DIGIT];
    assign slice_differs = (a_slice != b_slice);
    assign last_slice    = (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: a_q, b_q and idx are deliberately not reset; they are always loaded on the way into RUN
            // and never observed before that.
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            A_great_B <= 1'b0;
            A_equal_B <= 1'b0;
            A_less_B  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= signed_mode ? (A ^ MSB_MASK) : A;
                        b_q   <= signed_mode ? (B ^ MSB_MASK) : B;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (slice_differs || last_slice) begin
                        A_great_B <= (a_slice > b_slice);
                        A_equal_B <= !slice_differs;
                        A_less_B  <= (a_slice < b_slice);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + CW'(1);
                        a_q <= a_q << DIGIT;
                        b_q <= b_q << DIGIT;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_nb_seq.sv
// Directed bench for comparator_nb_seq: a DIGIT=1 and a DIGIT=4 instance (WIDTH=8) share clock, reset and operands.
// Each cycle's {busy, done, great, equal, less} is compared against hand-derived timelines.
module tb_comparator_nb_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1;
    logic       start4;
    logic       signed_mode;
    logic [7:0] A;
    logic [7:0] B;

    logic busy1, done1, g1, e1, l1;
    logic busy4, done4, g4, e4, l4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    comparator_nb_seq #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_mode(signed_mode), .A(A), .B(B),
        .busy(busy1), .done(done1), .A_great_B(g1), .A_equal_B(e1), .A_less_B(l1)
    );

    comparator_nb_seq #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(signed_mode), .A(A), .B(B),
        .busy(busy4), .done(done4), .A_great_B(g4), .A_equal_B(e4), .A_less_B(l4)
    );

    task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got {busy,done,gt,eq,lt}=%b, expected %b", tag, observed, expected);
        end
    endtask

    function automatic logic [4:0] outs(input int which);
        return (which == 1) ? {busy1, done1, g1, e1, l1} : {busy4, done4, g4, e4, l4};
    endfunction

    // Start a compare in cycle 0 and check cycles 1..j+2; flags are {gt,eq,lt}.
    task automatic run_compare(input string tag, input int which, input logic [7:0] a, input logic [7:0] b,
                               input logic sm, input int j, input logic [2:0] old_f, input logic [2:0] new_f);
        logic [4:0] exp_v;
        @(negedge clk);
        A = a; B = b; signed_mode = sm;
        if (which == 1) start1 = 1'b1; else start4 = 1'b1;
        for (int c = 1; c <= j + 2; c++) begin
            @(negedge clk);
            start1 = 1'b0; start4 = 1'b0;
            exp_v = {(c <= j), (c == j + 1), (c <= j) ? old_f : new_f};
            check($sformatf("%s c%0d", tag, c), outs(which), exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; signed_mode = 1'b0; A = '0; B = '0;

        // Reset and idle for 10 cycles, start held low.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("reset d1 c%0d", c), outs(1), 5'b00000);
            check($sformatf("reset d4 c%0d", c), outs(4), 5'b00000);
        end
        rst = 1'b0;

        // 0x80 vs 0x7F: MSB decides on slice 1.
        run_compare("unsigned 80>7F", 1, 8'h80, 8'h7F, 1'b0, 1, 3'b000, 3'b100);
        run_compare("signed 80<7F",   1, 8'h80, 8'h7F, 1'b1, 1, 3'b100, 3'b001);

        // Equal operands scan all 8 slices; operand change and extra start in cycle 3 are ignored.
        @(negedge clk);
        A = 8'hA5; B = 8'hA5; signed_mode = 1'b0; start1 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            check($sformatf("equal c%0d", c), outs(1),
                  {(c <= 8), (c == 9), (c <= 8) ? 3'b001 : 3'b010});
            if (c == 3) begin
                A = 8'hFF; start1 = 1'b1;
            end
        end

        // Reset mid-run: 0x12 vs 0x13 would finish in cycle 9; rst sampled at end of cycle 4.
        @(negedge clk);
        A = 8'h12; B = 8'h13; signed_mode = 1'b0; start1 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            rst = (c == 4);
            check($sformatf("abort c%0d", c), outs(1), (c <= 4) ? 5'b10010 : 5'b00000);
        end
        run_compare("rerun 12<13", 1, 8'h12, 8'h13, 1'b0, 8, 3'b000, 3'b001);

        // DIGIT=4: 0x3C vs 0x35 differ on slice 2; signed 0xF0 (-16) vs 0x10 differ on slice 1.
        run_compare("d4 3C>35",    4, 8'h3C, 8'h35, 1'b0, 2, 3'b000, 3'b100);
        run_compare("d4 sF0<10",   4, 8'hF0, 8'h10, 1'b1, 1, 3'b100, 3'b001);
        run_compare("d4 eq 5A",    4, 8'h5A, 8'h5A, 1'b0, 2, 3'b001, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
